// File: rtl/valve_line_tx.sv
// valve_line_tx: serialises one N_BITS valve word per frame onto a three-wire
// line (enable, clock, data) for a valve driver board.
//
// A frame is: line_sen rises, SEN_LEAD quiet cycles, N_BITS bit-slots of
// 4*QTR cycles each (LSB first), SEN_LAG quiet cycles, line_sen falls, then a
// MIN_GAP cycle gap before the next word can be taken. Inside a slot the data
// line is held at the bit value for the first half (which contains the sclk
// rising edge) and returns high for the second half, so a 0 bit is a low pulse
// and a 1 bit leaves the line high.
//
// Ports:
//   sys_clk    in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   tx_data    in   valve word, bit 0 sent first
//   tx_valid   in   tx_data is valid
//   tx_ready   out  block can accept a word (IDLE only)
//   line_sen   out  frame enable to the valve board
//   line_sclk  out  serial clock to the valve board
//   line_sdata out  serial data to the valve board, idles high
//   busy       out  frame or inter-frame gap in progress
//   done       out  one-cycle pulse when a frame completes
module valve_line_tx #(
  parameter int N_BITS   = 48,
  parameter int QTR      = 5,
  parameter int SEN_LEAD = 2,
  parameter int SEN_LAG  = 2,
  parameter int MIN_GAP  = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              line_sen,
  output logic              line_sclk,
  output logic              line_sdata,
  output logic              busy,
  output logic              done
);

  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CW = 16;

  localparam logic [CW-1:0] LEAD_END = CW'(SEN_LEAD - 1);
  localparam logic [CW-1:0] LAG_END  = CW'(SEN_LAG - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(MIN_GAP - 1);
  localparam logic [7:0]    QTR_END  = 8'(QTR - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(N_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LAG   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;       // LEAD / LAG / GAP cycle counter
  logic [7:0]        qcnt_r, qcnt_s;     // cycle within the current quarter
  logic [1:0]        qidx_r, qidx_s;     // quarter within the current slot
  logic [BW-1:0]     bit_r, bit_s;       // slot index
  logic [N_BITS-1:0] shreg_r, shreg_s;   // bit 0 is always the current bit
  logic              accept_s;
  logic              sen_s, sclk_s, sdata_s, busy_s, done_s;

  assign tx_ready = (state_r == ST_IDLE);
  assign accept_s = tx_valid && (state_r == ST_IDLE);

  // State, counter and shift-register storage
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      qcnt_r  <= 8'd0;
      qidx_r  <= 2'd0;
      bit_r   <= '0;
      shreg_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      qcnt_r  <= qcnt_s;
      qidx_r  <= qidx_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    qcnt_s  = qcnt_r;
    qidx_s  = qidx_r;
    bit_s   = bit_r;
    shreg_s = shreg_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_LEAD;
          shreg_s = tx_data;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (cnt_r == LEAD_END) begin
          state_s = ST_SHIFT;
          cnt_s   = '0;
          qcnt_s  = 8'd0;
          qidx_s  = 2'd0;
          bit_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_SHIFT: begin
        if (qcnt_r == QTR_END) begin
          qcnt_s = 8'd0;
          if (qidx_r == 2'd3) begin
            // end of slot: present the next bit in Q0 of the following slot
            qidx_s  = 2'd0;
            shreg_s = shreg_r >> 1'b1;
            if (bit_r == BIT_END) begin
              bit_s   = '0;
              state_s = ST_LAG;
              cnt_s   = '0;
            end else begin
              bit_s = bit_r + BW'(1);
            end
          end else begin
            qidx_s = qidx_r + 2'd1;
          end
        end else begin
          qcnt_s = qcnt_r + 8'd1;
        end
      end
      ST_LAG: begin
        if (cnt_r == LAG_END) begin
          state_s = ST_GAP;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_END) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        qcnt_s  = 8'd0;
        qidx_s  = 2'd0;
        bit_s   = '0;
        shreg_s = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it
  always_comb begin
    sen_s   = 1'b0;
    sclk_s  = 1'b0;
    sdata_s = 1'b1;
    busy_s  = (state_s != ST_IDLE);
    done_s  = (state_r == ST_GAP) && (state_s == ST_IDLE);
    case (state_s)
      ST_LEAD, ST_LAG: begin
        sen_s = 1'b1;
      end
      ST_SHIFT: begin
        sen_s  = 1'b1;
        // sclk is high in Q1 and Q2; data carries the bit only in Q0 and Q1
        sclk_s = (qidx_s == 2'd1) || (qidx_s == 2'd2);
        if (qidx_s[1] == 1'b0) begin
          sdata_s = shreg_s[0];
        end else begin
          sdata_s = 1'b1;
        end
      end
      default: begin
        sen_s = 1'b0;
      end
    endcase
  end

  // Output registers keep the line glitch-free
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      line_sen   <= 1'b0;
      line_sclk  <= 1'b0;
      line_sdata <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      line_sen   <= sen_s;
      line_sclk  <= sclk_s;
      line_sdata <= sdata_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

endmodule

// File: tb/tb_valve_line_tx.sv
// Directed bench for valve_line_tx: default instance for frame content,
// timing and control; a QTR=1, N_BITS=1 instance for the minimal frame.
module tb_valve_line_tx;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [47:0] tx_data;
  logic        tx_valid;
  logic        tx_ready, line_sen, line_sclk, line_sdata, busy, done;

  logic [0:0]  tx_data2;
  logic        tx_valid2;
  logic        tx_ready2, sen2, sclk2, sdata2, busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #25 sys_clk = ~sys_clk;

  valve_line_tx dut (
    .sys_clk(sys_clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .line_sen(line_sen), .line_sclk(line_sclk),
    .line_sdata(line_sdata), .busy(busy), .done(done)
  );

  valve_line_tx #(.N_BITS(1), .QTR(1)) dut_min (
    .sys_clk(sys_clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .line_sen(sen2), .line_sclk(sclk2),
    .line_sdata(sdata2), .busy(busy2), .done(done2)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- line monitor for the default instance ----------------
  logic        prev_sen = 1'b0, prev_sclk = 1'b0, prev_sdata = 1'b1, prev_ready = 1'b0;
  int          sen_len = 0, low_len = 0, pulse_cnt = 0, pulse_bad = 0, rx_n = 0;
  int          gap_len = 0, last_gap = 0, ready_len = 0, last_ready = 0, done_cnt = 0;
  logic [47:0] rx_word = 48'd0;
  logic [47:0] rx_q[$];
  int          len_q[$], rxn_q[$], pulse_q[$], bad_q[$];

  // Receiver model: samples sdata on sclk rise, measures sen and low pulses
  always @(negedge sys_clk) begin
    prev_sen   <= line_sen;
    prev_sclk  <= line_sclk;
    prev_sdata <= line_sdata;
    prev_ready <= tx_ready;
    if (done) done_cnt <= done_cnt + 1;
    if (line_sen) begin
      if (!prev_sen) begin
        sen_len   <= 1;
        rx_n      <= 0;
        rx_word   <= 48'd0;
        pulse_cnt <= 0;
        pulse_bad <= 0;
        last_gap  <= gap_len;
      end else begin
        sen_len <= sen_len + 1;
      end
    end else begin
      gap_len <= prev_sen ? 1 : gap_len + 1;
      if (prev_sen) begin
        rx_q.push_back(rx_word);
        len_q.push_back(sen_len);
        rxn_q.push_back(rx_n);
        pulse_q.push_back(pulse_cnt);
        bad_q.push_back(pulse_bad);
      end
    end
    if (line_sclk && !prev_sclk) begin
      if (rx_n < 48) rx_word[rx_n] <= line_sdata;
      rx_n <= rx_n + 1;
    end
    if (!line_sdata) begin
      low_len <= prev_sdata ? 1 : low_len + 1;
    end else if (!prev_sdata) begin
      pulse_cnt <= pulse_cnt + 1;
      if (low_len != 10) pulse_bad <= pulse_bad + 1;
    end
    if (tx_ready) begin
      ready_len <= prev_ready ? ready_len + 1 : 1;
    end else if (prev_ready) begin
      last_ready <= ready_len;
    end
  end

  // ---------------- monitor for the minimal instance ----------------
  logic prev_sen2 = 1'b0;
  int   s2_len = 0, k2_len = 0, lo2_len = 0, last_s2 = 0, last_k2 = 0, last_lo2 = 0, done2_cnt = 0;

  // Counts sen, sclk-high and sdata-low cycles of each minimal frame
  always @(negedge sys_clk) begin
    prev_sen2 <= sen2;
    if (done2) done2_cnt <= done2_cnt + 1;
    if (sen2) begin
      if (!prev_sen2) begin
        s2_len  <= 1;
        k2_len  <= sclk2 ? 1 : 0;
        lo2_len <= sdata2 ? 0 : 1;
      end else begin
        s2_len  <= s2_len + 1;
        k2_len  <= k2_len + (sclk2 ? 1 : 0);
        lo2_len <= lo2_len + (sdata2 ? 0 : 1);
      end
    end else if (prev_sen2) begin
      last_s2  <= s2_len;
      last_k2  <= k2_len;
      last_lo2 <= lo2_len;
    end
  end

  // ---------------- helpers ----------------
  task automatic send_word(input logic [47:0] w);
    @(posedge sys_clk); #1;
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge sys_clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n);
    for (int i = 0; i < 4000; i++) begin
      if (rx_q.size() >= n) break;
      @(negedge sys_clk);
    end
    if (rx_q.size() < n) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (tx_ready) break;
      @(negedge sys_clk);
    end
    if (!tx_ready) check_eq({tag, "_idle_timeout"}, 64'd0, 64'd1);
    @(negedge sys_clk);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] w);
    if (rx_q.size() == 0) begin
      check_eq({tag, "_noframe"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_word"},    rx_q.pop_front(), w);
      check_eq({tag, "_samples"}, rxn_q.pop_front(), 64'd48);
      check_eq({tag, "_senlen"},  len_q.pop_front(), 64'd964);
      check_eq({tag, "_pulses"},  pulse_q.pop_front(), 64'(48 - $countones(w)));
      check_eq({tag, "_pulselen"}, bad_q.pop_front(), 64'd0);
    end
  endtask

  task automatic flush_q();
    rx_q.delete(); len_q.delete(); rxn_q.delete(); pulse_q.delete(); bad_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [47:0] w;
    logic [63:0] r64;
    int          d0;

    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 48'd0;
    tx_valid2 = 1'b0;
    tx_data2  = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_sen",   line_sen,   1'b0);
    check_eq("rst_sclk",  line_sclk,  1'b0);
    check_eq("rst_sdata", line_sdata, 1'b1);
    check_eq("rst_busy",  busy,       1'b0);
    check_eq("rst_done",  done,       1'b0);
    check_eq("rst_ready", tx_ready,   1'b1);
    #5 rst = 1'b0;

    // reference word: ones at bits 0, 3, 24, 47
    d0 = done_cnt;
    send_word(48'h8000_0100_0009);
    check_eq("ref_busy", busy, 1'b1);
    wait_frames("ref", 1);
    check_frame("ref", 48'h8000_0100_0009);
    wait_idle("ref");
    check_eq("ref_done", done_cnt, d0 + 1);

    // minimal instance: one 0 bit, QTR=1
    @(posedge sys_clk); #1;
    tx_valid2 = 1'b1;
    @(posedge sys_clk); #1;
    tx_valid2 = 1'b0;
    repeat (20) @(negedge sys_clk);
    check_eq("min_senlen", last_s2,   64'd8);
    check_eq("min_sclk",   last_k2,   64'd2);
    check_eq("min_low",    last_lo2,  64'd2);
    check_eq("min_done",   done2_cnt, 64'd1);

    // content patterns
    send_word(48'd0);
    wait_frames("zero", 1);
    check_frame("zero", 48'd0);
    wait_idle("zero");
    send_word(48'hFFFF_FFFF_FFFF);
    wait_frames("ones", 1);
    check_frame("ones", 48'hFFFF_FFFF_FFFF);
    wait_idle("ones");
    r64 = {$urandom(), $urandom()};
    w   = r64[47:0];
    send_word(w);
    wait_frames("rand", 1);
    check_frame("rand", w);
    wait_idle("rand");

    // back-to-back with tx_valid held high
    d0 = done_cnt;
    @(posedge sys_clk); #1;
    tx_data  = 48'h0123_4567_89AB;
    tx_valid = 1'b1;
    @(posedge sys_clk); #1;
    tx_data  = 48'hFEDC_BA98_7654;
    wait_frames("b2b_a", 1);
    for (int i = 0; i < 20; i++) begin
      if (line_sen) break;
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    @(negedge sys_clk);
    check_eq("b2b_gap",   last_gap,   64'd5);
    check_eq("b2b_ready", last_ready, 64'd1);
    wait_frames("b2b_b", 2);
    check_frame("b2b_a", 48'h0123_4567_89AB);
    check_frame("b2b_b", 48'hFEDC_BA98_7654);
    wait_idle("b2b");
    check_eq("b2b_done", done_cnt, d0 + 2);

    // tx_valid and tx_data disturbed mid-SHIFT
    send_word(48'h1234_5678_9ABC);
    repeat (300) @(negedge sys_clk);
    tx_data  = 48'hEDCB_A987_6543;
    tx_valid = 1'b1;
    check_eq("ign_ready", tx_ready, 1'b0);
    repeat (3) @(negedge sys_clk);
    tx_valid = 1'b0;
    wait_frames("ign", 1);
    check_frame("ign", 48'h1234_5678_9ABC);
    wait_idle("ign");
    repeat (10) @(negedge sys_clk);
    check_eq("ign_extra", rx_q.size(), 64'd0);

    // reset at bit 20, Q1
    send_word(48'd0);
    for (int i = 0; i < 2000; i++) begin
      if (rx_n == 21 && line_sen) break;
      @(negedge sys_clk);
    end
    check_eq("mid_sclk_pre",  line_sclk,  1'b1);
    check_eq("mid_sdata_pre", line_sdata, 1'b0);
    #5 rst = 1'b1;
    #1;
    check_eq("mid_sen",   line_sen,   1'b0);
    check_eq("mid_sclk",  line_sclk,  1'b0);
    check_eq("mid_sdata", line_sdata, 1'b1);
    check_eq("mid_busy",  busy,       1'b0);
    check_eq("mid_ready", tx_ready,   1'b1);
    repeat (2) @(negedge sys_clk);
    #5 rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    flush_q();
    send_word(48'hA5A5_0F0F_C3C3);
    wait_frames("post", 1);
    check_frame("post", 48'hA5A5_0F0F_C3C3);
    wait_idle("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
